// File: rtl/mem_access_ctrl.sv
// Memory-stage controller for KGP_miniRISC: validates byte addresses, drives the
// data BRAM write/read timing and returns results on a valid/ready response channel.
module mem_access_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              MemwrEna,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] bram_dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

  state_t              state_q, state_d;
  logic                memwr_q, memwr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [1:0]          cnt_q, cnt_d;

  logic                accept_s;
  logic                bad_addr_s;
  logic [ADDR_W-1:0]   word_s;

  assign req_ready  = (state_q == IDLE) & rst_n;
  assign accept_s   = req_valid & req_ready;
  // Misaligned or beyond the BRAM depth; such requests never touch the BRAM.
  assign bad_addr_s = (req_addr[1:0] != 2'b00) | (req_addr[31:ADDR_W+2] != '0);
  assign word_s     = req_addr[ADDR_W+1:2];

  // Next-state and next-output computation for the request/response sequencer.
  always_comb begin
    state_d     = state_q;
    memwr_d     = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (bad_addr_s) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
            rdata_d     = '0;
          end else if (req_we) begin
            state_d = WR;
            memwr_d = 1'b1;
            addr_d  = word_s;
            din_d   = req_wdata;
          end else begin
            state_d = RD_WAIT;
            addr_d  = word_s;
            cnt_d   = LAT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        err_d       = 1'b0;
        rdata_d     = '0;
      end
      RD_WAIT: begin
        // Counter hits zero on the edge where bram_dout reflects the sampled address.
        if (cnt_q == 2'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          err_d       = 1'b0;
          rdata_d     = bram_dout;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      memwr_q     <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      memwr_q     <= memwr_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign MemwrEna  = memwr_q;
  assign addr      = addr_q;
  assign din       = din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: two instances (read latency 1 and 3), each
// with a behavioural BRAM, a reference memory model and a response monitor.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          vcyc;
  } exp_t;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;

    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              memwr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
    logic [31:0]       bram_dout;

    bit done = 1'b0;
    bit hold_lo = 1'b0;
    bit force_rdy = 1'b0;
    exp_t q[$];
    logic [31:0] ref_mem [int];
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [31:0] prev_din = 32'd0;

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .MemwrEna(memwr), .addr(addr), .din(din), .bram_dout(bram_dout)
    );

    // Synchronous BRAM: address sampled at an edge, data valid LAT edges later.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] pipe [0:LAT-1];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
      if (!mem_init) begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 32'd0;
        mem_init <= 1'b1;
      end else if (memwr) begin
        mem[addr] <= din;
      end
      pipe[0] <= mem[addr];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_dout = pipe[LAT-1];

    initial forever begin
      @(posedge clk); #1;
      rsp_ready = force_rdy ? 1'b1 : hold_lo ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard when a response appears and checks it while held.
    exp_t cur;
    bit in_rsp = 1'b0;
    bit hs_prev = 1'b0;
    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_rsp = 1'b0;
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) check($sformatf("L%0d ready_after_rsp", LAT), 32'(req_ready), 32'd1);
        hs_prev = 1'b0;
        if (rsp_valid) begin
          check($sformatf("L%0d ready_low_in_rsp", LAT), 32'(req_ready), 32'd0);
          if (!in_rsp) begin
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL L%0d unexpected_rsp: got rdata %0h err %0b with no request pending", LAT, rsp_rdata, rsp_err);
              cur.rdata = rsp_rdata; cur.err = rsp_err; cur.vcyc = cyc;
            end else begin
              cur = q.pop_front();
              check($sformatf("L%0d rsp_rdata", LAT), rsp_rdata, cur.rdata);
              check($sformatf("L%0d rsp_err", LAT), 32'(rsp_err), 32'(cur.err));
              check($sformatf("L%0d rsp_cycle", LAT), 32'(cyc), 32'(cur.vcyc));
            end
            in_rsp = 1'b1;
          end else begin
            check($sformatf("L%0d hold_rdata", LAT), rsp_rdata, cur.rdata);
            check($sformatf("L%0d hold_err", LAT), 32'(rsp_err), 32'(cur.err));
          end
          if (rsp_ready) begin
            in_rsp = 1'b0;
            hs_prev = 1'b1;
          end
        end else if (in_rsp) begin
          checks++; errors++;
          $display("FAIL L%0d rsp_dropped: rsp_valid got 0 expected 1", LAT);
          in_rsp = 1'b0;
        end
      end
    end

    task automatic tick();
      @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
      check($sformatf("L%0d %s MemwrEna", LAT, tag), 32'(memwr), 32'd0);
      check($sformatf("L%0d %s addr", LAT, tag), 32'(addr), 32'd0);
      check($sformatf("L%0d %s din", LAT, tag), din, 32'd0);
      check($sformatf("L%0d %s rsp_valid", LAT, tag), 32'(rsp_valid), 32'd0);
      check($sformatf("L%0d %s rsp_rdata", LAT, tag), rsp_rdata, 32'd0);
      check($sformatf("L%0d %s rsp_err", LAT, tag), 32'(rsp_err), 32'd0);
      check($sformatf("L%0d %s req_ready", LAT, tag), 32'(req_ready), 32'd0);
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd, input bit abort);
      int n = 0;
      bit err;
      logic [ADDR_W-1:0] w;
      exp_t e;
      while (!req_ready && n < 200) begin tick(); n++; end
      if (!req_ready) begin
        checks++; errors++;
        $display("FAIL L%0d ready_timeout: req_ready got 0 expected 1 within 200 cycles", LAT);
        return;
      end
      err = (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
      w = a[ADDR_W+1:2];
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
      e.err = err;
      e.rdata = (err || we) ? 32'd0 : (ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : 32'd0);
      e.vcyc = cyc + 1 + (err ? 0 : (we ? 1 : 1 + LAT));
      if (!abort) q.push_back(e);
      tick();
      // Scramble request inputs right after accept; the DUT must ignore them.
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      if (err) begin
        check($sformatf("L%0d err_no_write", LAT), 32'(memwr), 32'd0);
        check($sformatf("L%0d err_addr_held", LAT), 32'(addr), 32'(prev_addr));
        check($sformatf("L%0d err_din_held", LAT), din, prev_din);
      end else if (we) begin
        check($sformatf("L%0d wr_MemwrEna", LAT), 32'(memwr), 32'd1);
        check($sformatf("L%0d wr_addr", LAT), 32'(addr), 32'(w));
        check($sformatf("L%0d wr_din", LAT), din, wd);
        prev_addr = w; prev_din = wd;
      end else begin
        check($sformatf("L%0d rd_no_write", LAT), 32'(memwr), 32'd0);
        check($sformatf("L%0d rd_addr", LAT), 32'(addr), 32'(w));
        prev_addr = w;
      end
      if (we && !err) begin
        if (abort) begin
          #2 rst_n = 1'b0;
          #1 check_reset_vals("rst_in_wr");
          @(posedge clk); #1;
          rst_n = 1'b1;
          #1 check($sformatf("L%0d ready_after_rst", LAT), 32'(req_ready), 32'd1);
          prev_addr = '0; prev_din = 32'd0;
        end else begin
          ref_mem[int'(w)] = wd;
          tick();
          check($sformatf("L%0d wr_one_cycle", LAT), 32'(memwr), 32'd0);
        end
      end
    endtask

    initial begin
      int n;
      logic [31:0] a;
      int r;
      repeat (3) tick();
      check_reset_vals("reset");
      rst_n = 1'b1;
      tick();
      check($sformatf("L%0d ready_out_of_reset", LAT), 32'(req_ready), 32'd1);

      issue(1'b1, 32'h0, 32'd69, 1'b0);
      issue(1'b1, 32'h4, 32'd459, 1'b0);
      issue(1'b0, 32'h4, 32'd0, 1'b0);
      issue(1'b0, 32'h0, 32'd0, 1'b0);
      issue(1'b0, 32'h6, 32'd0, 1'b0);
      issue(1'b1, 32'h8000, 32'h1234_5678, 1'b0);
      check($sformatf("L%0d bram_word0", LAT), mem[0], 32'd69);
      check($sformatf("L%0d bram_word1", LAT), mem[1], 32'd459);

      // Consumer stalls for several cycles on a load response.
      hold_lo = 1'b1;
      issue(1'b0, 32'h4, 32'd0, 1'b0);
      n = 0;
      while (!rsp_valid && n < 50) begin tick(); n++; end
      repeat (5) tick();
      hold_lo = 1'b0;
      force_rdy = 1'b1;
      n = 0;
      while (rsp_valid && n < 20) begin tick(); n++; end
      force_rdy = 1'b0;

      issue(1'b1, 32'h8, 32'hDEAD_BEEF, 1'b1);
      issue(1'b0, 32'h8, 32'd0, 1'b0);
      issue(1'b1, 32'hC, 32'hCAFE_0001, 1'b0);
      issue(1'b0, 32'hC, 32'd0, 1'b0);

      repeat (40) begin
        r = $urandom_range(0, 9);
        if (r == 0) a = ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
        else if (r == 1) a = ($urandom & 32'hFFFF_FFFC) | (32'h1 << $urandom_range(15, 31));
        else a = $urandom_range(0, 15) << 2;
        issue(1'($urandom), a, $urandom, 1'b0);
      end

      n = 0;
      while ((q.size() != 0 || !req_ready) && n < 200) begin tick(); n++; end
      if (q.size() != 0 || !req_ready) begin
        checks++; errors++;
        $display("FAIL L%0d drain_timeout: %0d responses still pending", LAT, q.size());
      end
      for (int i = 0; i < 16; i++)
        check($sformatf("L%0d final_mem[%0d]", LAT, i), mem[i], ref_mem.exists(i) ? ref_mem[i] : 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(u[0].done && u[1].done) && n < 20000) begin @(posedge clk); n++; end
    if (!(u[0].done && u[1].done)) begin
      checks++; errors++;
      $display("FAIL global_timeout: stimulus not complete after %0d cycles", n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage controller for KGP_miniRISC, directly upstream of the data BRAM block. It accepts one load or store request at a time from the execute stage, checks the byte address, and drives the BRAM write-enable, word address and write data. It waits out the BRAM read latency, then returns read data or an error on a valid/ready response channel. It owns all BRAM timing, so the pipeline only sees a simple request/response handshake.

## Interface

- ADDR_W, 13: BRAM word-address width (depth 2^ADDR_W words).
- DATA_W, 32: data width.
- RD_LAT, 1: BRAM read latency in cycles, from address sampled to dout valid; legal range 1..3.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range address.
- MemwrEna  out  1  BRAM write enable.
- addr  out  ADDR_W  BRAM word address.
- din  out  DATA_W  BRAM write data.
- bram_dout  in  DATA_W  BRAM read data.

## Operation

- States: IDLE, WR, RD_WAIT, RESP.
- req_ready = (state==IDLE) & rst_n. Accept = req_valid & req_ready at a rising edge.
- Address check at accept:
  - misaligned if req_addr[1:0] != 0;
  - out of range if req_addr[31:ADDR_W+2] != 0.
  - Word address = req_addr[ADDR_W+1:2].
- Error request: go to RESP with rsp_err=1 and rsp_rdata=0. The BRAM is not touched: MemwrEna stays 0 and addr/din keep their previous values.
- Store: go to WR. Register MemwrEna=1, addr=word address, din=req_wdata.
  - WR lasts exactly one cycle; MemwrEna returns to 0 on leaving WR.
  - Then RESP with rsp_rdata=0 and rsp_err=0.
- Load: go to RD_WAIT. Register addr=word address with MemwrEna=0, and load the wait counter with RD_LAT.
  - The counter decrements each cycle.
  - When it reaches 0, capture bram_dout into rsp_rdata and go to RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err hold stable until rsp_valid & rsp_ready at an edge, then go to IDLE.
- din is held after a store; addr is held until the next accepted non-error request.
- Only one outstanding request; there is no pipelining or overlap.

## Timing

- Reset (rst_n low, asynchronous):
  - state=IDLE; MemwrEna=0, addr=0, din=0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0; req_ready=0.
- Reset assertion during WR drops MemwrEna immediately; the BRAM write is aborted with no commit guaranteed.
- Reset during RD_WAIT or RESP discards the pending response.
- With accept at edge k:
  - Error: rsp_valid high in cycle k+1.
  - Store: MemwrEna high only in cycle k+1 and the BRAM commits at edge k+1; rsp_valid high in cycle k+2.
  - Load: addr valid from cycle k+1; bram_dout captured at edge k+1+RD_LAT; rsp_valid high in cycle k+2+RD_LAT (cycle k+3 for RD_LAT=1).
- Response consumed at edge m: req_ready=1 in cycle m+1. Best-case throughput is one store per 3 cycles.
- If rsp_ready is already high when rsp_valid rises, the response completes at the next edge.
- req_* inputs are ignored when req_ready=0. They are sampled only at the accept edge, so changes after accept have no effect.

## Test plan

- Reset, then store 69 to byte addr 0x0 -> MemwrEna=1 for exactly one cycle with addr=0, din=69; rsp_valid 2 cycles after accept with rsp_err=0, rsp_rdata=0.
- Store 459 to 0x4, then load 0x4 and load 0x0 -> addr=1 during the store; loads return 459 and 69 respectively, rsp_valid 3 cycles after accept (RD_LAT=1); repeat with RD_LAT=3 -> 5 cycles.
- Load from 0x6, and store to 0x8000 (word 8192, out of range) -> rsp_err=1 one cycle after accept, rsp_rdata=0, MemwrEna never asserted, BRAM contents at words 0/1 unchanged.
- Load with rsp_ready held low for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable throughout, req_ready=0 throughout; req_ready=1 in the cycle after the rsp_ready edge.
- rst_n pulsed low during the WR cycle of a store of 0xDEADBEEF to 0x8 -> MemwrEna falls asynchronously, all outputs at reset values, rsp_valid never asserted; req_ready=1 after release; the next request proceeds normally.
- Change req_addr and req_wdata one cycle after accept -> the BRAM sees only the originally sampled values.
